// File: rtl/hsci_slave_pkg.sv
// Shared types and constants for the HSCI far-end responder.
// Parity checking is enabled by defining HSCI_SLV_PARITY_EN.
package hsci_slave_pkg;

  localparam logic [7:0] HSCI_SOF     = 8'hA5;
  localparam logic [3:0] HSCI_RSP_TAG = 4'hA;

  typedef enum logic [3:0] {
    StIdle,
    StInstr,
    StAddr,
    StWdata,
    StPar,
    StExec,
    StWaitRd,
    StRspSt,
    StRspData,
    StRspPar
  } hsci_slv_state_t;

  typedef enum logic [3:0] {
    ErrNone    = 4'h0,
    ErrParity  = 4'h1,
    ErrInstr   = 4'h2,
    ErrTimeout = 4'h3
  } hsci_slv_err_t;

  typedef enum logic [1:0] {
    EncIdle,
    EncData,
    EncPar
  } hsci_enc_stage_t;

  function automatic logic [2:0] tsize_to_nbytes(input logic [1:0] tsize);
    case (tsize)
      2'b01:   return 3'd2;
      2'b10:   return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/hsci_slave_rsp_enc.sv
// Response serialiser: status byte, then the low nbytes of word MSB first, then XOR parity.
// MISO is registered; the status byte appears the cycle after load.
module hsci_slave_rsp_enc
  import hsci_slave_pkg::*;
(
  input  logic        hsci_pclk,
  input  logic        hsci_rst,
  input  logic        load,
  input  logic [31:0] word,
  input  logic [2:0]  nbytes,
  input  logic [3:0]  err,
  output logic [7:0]  miso
);

  hsci_enc_stage_t stage_q, stage_d;
  logic [31:0]     shift_q, shift_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [7:0]      par_q, par_d;
  logic [7:0]      miso_q, miso_d;
  logic [7:0]      status;

  assign status = {HSCI_RSP_TAG, err};

  always_comb begin
    stage_d = stage_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    miso_d  = 8'h00;
    if (load) begin
      miso_d  = status;
      par_d   = status;
      cnt_d   = nbytes;
      stage_d = (nbytes != 3'd0) ? EncData : EncPar;
      // Left-align the selected bytes so data always leaves from [31:24].
      case (nbytes)
        3'd1:    shift_d = {word[7:0], 24'h0};
        3'd2:    shift_d = {word[15:0], 16'h0};
        default: shift_d = word;
      endcase
    end else begin
      unique case (stage_q)
        EncData: begin
          miso_d  = shift_q[31:24];
          par_d   = par_q ^ shift_q[31:24];
          shift_d = {shift_q[23:0], 8'h00};
          cnt_d   = cnt_q - 3'd1;
          if (cnt_q == 3'd1) stage_d = EncPar;
        end
        EncPar: begin
          miso_d  = par_q;
          stage_d = EncIdle;
        end
        default: stage_d = EncIdle;
      endcase
    end
  end

  always_ff @(posedge hsci_pclk) begin
    if (hsci_rst) begin
      stage_q <= EncIdle;
      shift_q <= 32'h0;
      cnt_q   <= 3'd0;
      par_q   <= 8'h00;
      miso_q  <= 8'h00;
    end else begin
      stage_q <= stage_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      miso_q  <= miso_d;
    end
  end

  assign miso = miso_q;

endmodule

// File: rtl/hsci_slave_responder.sv
// HSCI far-end responder: decodes MOSI frames, drives the register port, encodes MISO replies.
// Define HSCI_SLV_PARITY_EN to check the request PAR byte.
module hsci_slave_responder
  import hsci_slave_pkg::*;
#(
  parameter int unsigned ADDR_BYTES = 4,
  parameter int unsigned RD_TIMEOUT = 64
) (
  input  logic                    hsci_pclk,
  input  logic                    hsci_rst,
  input  logic [7:0]              hsci_mosi_data,
  output logic [7:0]              hsci_miso_data,
  output logic [8*ADDR_BYTES-1:0] reg_addr,
  output logic [31:0]             reg_wdata,
  output logic                    reg_wr,
  output logic                    reg_rd,
  input  logic [31:0]             reg_rdata,
  input  logic                    reg_rd_valid,
  output logic [15:0]             frame_cnt,
  output logic [15:0]             err_cnt,
  output logic [3:0]              last_err
);

  localparam int unsigned AW = 8 * ADDR_BYTES;
  localparam int unsigned TW = $clog2(RD_TIMEOUT);

  hsci_slv_state_t state_q, state_d;
  hsci_slv_err_t   err_q, err_d, last_err_q, last_err_d;
  logic            rnw_q, rnw_d;
  logic            rd_done_q, rd_done_d;
  logic [2:0]      nbytes_q, nbytes_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;
  logic [15:0]     err_cnt_q, err_cnt_d;
  logic            enc_load;
  logic [2:0]      rsp_n;
  logic            par_bad;
  logic            illegal;

`ifdef HSCI_SLV_PARITY_EN
  logic [7:0] par_acc_q, par_acc_d;

  always_comb begin
    par_acc_d = par_acc_q;
    if (state_q == StIdle) begin
      par_acc_d = 8'h00;
    end else if (state_q == StInstr || state_q == StAddr || state_q == StWdata) begin
      par_acc_d = par_acc_q ^ hsci_mosi_data;
    end
  end

  always_ff @(posedge hsci_pclk) begin
    if (hsci_rst) par_acc_q <= 8'h00;
    else          par_acc_q <= par_acc_d;
  end

  assign par_bad = (par_acc_q != hsci_mosi_data);
`else
  assign par_bad = 1'b0;
`endif

  assign illegal = hsci_mosi_data[6] || (hsci_mosi_data[3:0] != 4'h0) ||
                   (hsci_mosi_data[5:4] == 2'b11);
  // Data bytes only accompany a successful read.
  assign rsp_n   = (rnw_q && err_q == ErrNone) ? nbytes_q : 3'd0;

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    last_err_d  = last_err_q;
    rnw_d       = rnw_q;
    rd_done_d   = rd_done_q;
    nbytes_d    = nbytes_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    reg_wr      = 1'b0;
    reg_rd      = 1'b0;
    enc_load    = 1'b0;
    unique case (state_q)
      StIdle: if (hsci_mosi_data == HSCI_SOF) state_d = StInstr;
      StInstr: begin
        wdata_d   = 32'h0;
        rd_done_d = 1'b0;
        cnt_d     = 3'd0;
        tmo_d     = '0;
        if (illegal) begin
          // Consume the rest as a 1-byte read frame but never touch the register port.
          rnw_d    = 1'b1;
          nbytes_d = 3'd1;
          err_d    = ErrInstr;
        end else begin
          rnw_d    = hsci_mosi_data[7];
          nbytes_d = tsize_to_nbytes(hsci_mosi_data[5:4]);
          err_d    = ErrNone;
        end
        state_d = StAddr;
      end
      StAddr: begin
        addr_d = AW'({addr_q, hsci_mosi_data});
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'(ADDR_BYTES - 1)) begin
          cnt_d   = 3'd0;
          state_d = rnw_q ? StPar : StWdata;
        end
      end
      StWdata: begin
        wdata_d = {wdata_q[23:0], hsci_mosi_data};
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == nbytes_q - 3'd1) begin
          cnt_d   = 3'd0;
          state_d = StPar;
        end
      end
      StPar: begin
        if (par_bad && err_q == ErrNone) err_d = ErrParity;
        state_d = StExec;
      end
      StExec: begin
        // Entered twice on reads: once to strobe reg_rd, once after the data is captured.
        if (err_q != ErrNone || rd_done_q) begin
          enc_load = 1'b1;
          state_d  = StRspSt;
        end else if (!rnw_q) begin
          reg_wr   = 1'b1;
          enc_load = 1'b1;
          state_d  = StRspSt;
        end else begin
          reg_rd  = 1'b1;
          state_d = StWaitRd;
        end
      end
      StWaitRd: begin
        if (reg_rd_valid) begin
          rdata_d   = reg_rdata;
          rd_done_d = 1'b1;
          state_d   = StExec;
        end else if (tmo_q == TW'(RD_TIMEOUT - 1)) begin
          err_d     = ErrTimeout;
          rdata_d   = 32'h0;
          rd_done_d = 1'b1;
          state_d   = StExec;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StRspSt: begin
        cnt_d   = 3'd0;
        state_d = (rsp_n != 3'd0) ? StRspData : StRspPar;
      end
      StRspData: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == rsp_n - 3'd1) state_d = StRspPar;
      end
      StRspPar: begin
        if (err_q == ErrNone)         frame_cnt_d = frame_cnt_q + 16'd1;
        else if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        last_err_d = err_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge hsci_pclk) begin
    if (hsci_rst) begin
      state_q     <= StIdle;
      err_q       <= ErrNone;
      last_err_q  <= ErrNone;
      rnw_q       <= 1'b0;
      rd_done_q   <= 1'b0;
      nbytes_q    <= 3'd0;
      cnt_q       <= 3'd0;
      tmo_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      rdata_q     <= 32'h0;
      frame_cnt_q <= 16'h0;
      err_cnt_q   <= 16'h0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      last_err_q  <= last_err_d;
      rnw_q       <= rnw_d;
      rd_done_q   <= rd_done_d;
      nbytes_q    <= nbytes_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  hsci_slave_rsp_enc u_rsp_enc (
    .hsci_pclk (hsci_pclk),
    .hsci_rst  (hsci_rst),
    .load      (enc_load),
    .word      (rdata_q),
    .nbytes    (rsp_n),
    .err       (err_q),
    .miso      (hsci_miso_data)
  );

  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
  assign last_err  = last_err_q;

endmodule

// File: tb/tb_hsci_slave_responder.sv
// Scoreboard bench for hsci_slave_responder: directed frames plus randomized traffic.
module tb_hsci_slave_responder;

  localparam int AB = 4;
  localparam int TO = 64;
`ifdef HSCI_SLV_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    int              cyc;
    int              len;
    logic [5:0][7:0] b;
  } rsp_t;
  typedef struct packed {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  typedef struct packed {
    int          cyc;
    logic [31:0] addr;
    int          lat;
    logic [31:0] rdata;
  } rd_t;

  logic        clk = 1'b0;
  logic        hsci_rst;
  logic [7:0]  mosi;
  logic [7:0]  miso;
  logic [31:0] reg_addr, reg_wdata, reg_rdata;
  logic        reg_wr, reg_rd, reg_rd_valid;
  logic [15:0] frame_cnt, err_cnt;
  logic [3:0]  last_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rsp_issued = 0;
  int rsp_done = 0;
  int rd_strobes = 0;
  int exp_rd_strobes = 0;
  int m_frames = 0;
  int m_errs = 0;
  int m_last = 0;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  rd_t  rd_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hsci_slave_responder #(.ADDR_BYTES(AB), .RD_TIMEOUT(TO)) dut (
    .hsci_pclk      (clk),
    .hsci_rst       (hsci_rst),
    .hsci_mosi_data (mosi),
    .hsci_miso_data (miso),
    .reg_addr       (reg_addr),
    .reg_wdata      (reg_wdata),
    .reg_wr         (reg_wr),
    .reg_rd         (reg_rd),
    .reg_rdata      (reg_rdata),
    .reg_rd_valid   (reg_rd_valid),
    .frame_cnt      (frame_cnt),
    .err_cnt        (err_cnt),
    .last_err       (last_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic [7:0] b);
    @(posedge clk);
    #1 mosi = b;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_miso"}, 32'(miso), 32'h0);
    chk({tag, "_reg_wr"}, 32'(reg_wr), 32'h0);
    chk({tag, "_reg_rd"}, 32'(reg_rd), 32'h0);
    chk({tag, "_reg_addr"}, reg_addr, 32'h0);
    chk({tag, "_reg_wdata"}, reg_wdata, 32'h0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'h0);
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'h0);
    chk({tag, "_last_err"}, 32'(last_err), 32'h0);
  endtask

  // Sends one frame, queues every expected observable, then waits for the reply.
  task automatic send_frame(input logic [7:0] instr, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit corrupt, input int lat,
                            input logic [31:0] rdata, input int nstray);
    logic        illegal, rnw, par_err, access;
    int          n, err, p, k;
    logic [7:0]  par, sb;
    logic [7:0]  fb[$];
    logic [31:0] mask;
    rsp_t        r;
    wr_t         w;
    rd_t         rr;
    illegal = instr[6] || (instr[3:0] != 4'h0) || (instr[5:4] == 2'b11);
    rnw     = illegal ? 1'b1 : instr[7];
    n       = illegal ? 1 : (instr[5:4] == 2'b00) ? 1 : (instr[5:4] == 2'b01) ? 2 : 4;
    mask    = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
    fb.push_back(instr);
    for (int i = AB - 1; i >= 0; i--) fb.push_back(addr[8*i +: 8]);
    if (!rnw) for (int i = n - 1; i >= 0; i--) fb.push_back(wdata[8*i +: 8]);
    par = 8'h00;
    foreach (fb[i]) par ^= fb[i];
    par_err = corrupt && PAR_EN;
    access  = !illegal && !par_err;
    err     = illegal ? 2 : par_err ? 1 : (rnw && lat == 0) ? 3 : 0;

    for (int i = 0; i < nstray; i++) begin
      do sb = 8'($urandom); while (sb == 8'hA5);
      drive(sb);
    end
    drive(8'hA5);
    foreach (fb[i]) drive(fb[i]);
    drive(corrupt ? (par ^ 8'h5A) : par);
    p = cyc;

    if (access && !rnw) begin
      w.cyc = p + 1; w.addr = addr; w.data = wdata & mask;
      wr_q.push_back(w);
    end
    if (access && rnw) begin
      rr.cyc = p + 1; rr.addr = addr; rr.lat = lat; rr.rdata = rdata;
      rd_q.push_back(rr);
      exp_rd_strobes++;
    end
    r.b   = '0;
    r.b[0] = {4'hA, 4'(err)};
    r.len = 1;
    if (err == 0 && rnw) begin
      for (int i = n - 1; i >= 0; i--) begin
        r.b[r.len] = rdata[8*i +: 8];
        r.len++;
      end
    end
    sb = 8'h00;
    for (int i = 0; i < r.len; i++) sb ^= r.b[i];
    r.b[r.len] = sb;
    r.len++;
    if (access && rnw) r.cyc = (lat == 0) ? p + 1 + TO + 2 : p + 1 + lat + 2;
    else               r.cyc = p + 2;
    rsp_q.push_back(r);
    rsp_issued++;
    if (err == 0) m_frames = (m_frames + 1) % 65536;
    else if (m_errs < 65535) m_errs++;
    m_last = err;

    drive(8'hA5);  // lands in EXEC and must be ignored
    drive(8'h00);
    k = 0;
    while (rsp_done != rsp_issued && k < 300) begin
      @(posedge clk);
      k++;
    end
    if (rsp_done != rsp_issued) chk("rsp_wait_timeout", 32'(rsp_done), 32'(rsp_issued));
    @(posedge clk);
    #1;
    chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
    chk("err_cnt", 32'(err_cnt), 32'(m_errs));
    chk("last_err", 32'(last_err), 32'(m_last));
  endtask

  // MISO monitor
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!hsci_rst && miso != 8'h00) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(miso), 32'h0);
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_latency", 32'(cyc), 32'(e.cyc));
          for (int i = 0; i < e.len; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("rsp_byte%0d", i), 32'(miso), 32'(e.b[i]));
          end
          @(negedge clk);
          chk("rsp_end_idle", 32'(miso), 32'h0);
          rsp_done++;
        end
      end
    end
  end

  // Write-strobe monitor
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (!hsci_rst && reg_wr) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_reg_wr", reg_addr, 32'h0);
        end else begin
          w = wr_q.pop_front();
          chk("wr_cycle", 32'(cyc), 32'(w.cyc));
          chk("wr_addr", reg_addr, w.addr);
          chk("wr_data", reg_wdata, w.data);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!hsci_rst && reg_rd) rd_strobes++;
    end
  end

  // Register-port read responder; also drives a stray valid outside WAIT_RD.
  initial begin
    rd_t r;
    reg_rd_valid = 1'b0;
    reg_rdata    = 32'h0;
    forever begin
      @(negedge clk);
      if (!hsci_rst && reg_rd) begin
        if (rd_q.size() == 0) begin
          chk("unexpected_reg_rd", reg_addr, 32'h0);
        end else begin
          r = rd_q.pop_front();
          chk("rd_cycle", 32'(cyc), 32'(r.cyc));
          chk("rd_addr", reg_addr, r.addr);
          if (r.lat > 0) begin
            repeat (r.lat) @(posedge clk);
            #1 reg_rd_valid = 1'b1;
            reg_rdata = r.rdata;
            @(posedge clk);
            #1 reg_rd_valid = 1'b0;
            reg_rdata = $urandom;
            @(posedge clk);
            #1 reg_rd_valid = 1'b1;
            @(posedge clk);
            #1 reg_rd_valid = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired actual=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  instr;
    logic [31:0] addr;
    int          lat;
    hsci_rst = 1'b1;
    mosi     = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    hsci_rst = 1'b0;

    send_frame(8'h20, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 0, 32'h0, 0);
    send_frame(8'h90, 32'h0000_0004, 32'h0, 1'b0, 3, 32'h1234_ABCD, 0);
    send_frame(8'h80, 32'h0000_0008, 32'h0, 1'b0, 0, 32'h0, 0);
    send_frame(8'h01, 32'h0000_0010, 32'h0, 1'b0, 5, 32'h5555_AAAA, 0);
    send_frame(8'h20, 32'h0000_0020, 32'hCAFE_F00D, 1'b1, 0, 32'h0, 0);
    drive(8'h00);
    drive(8'h3C);
    drive(8'hFF);
    send_frame(8'h00, 32'hA5A5_00A5, 32'h0000_00A5, 1'b0, 0, 32'h0, 0);
    send_frame(8'hA0, 32'h0000_0030, 32'h0, 1'b0, TO, 32'h8765_4321, 2);

    // Abandon a write right after its address bytes.
    drive(8'hA5);
    drive(8'h20);
    drive(8'h12); drive(8'h34); drive(8'h56); drive(8'h78);
    @(posedge clk);
    #1 hsci_rst = 1'b1;
    mosi = 8'h00;
    @(posedge clk);
    #1;
    chk_all_zero("midframe_reset");
    hsci_rst = 1'b0;
    m_frames = 0;
    m_errs   = 0;
    m_last   = 0;
    send_frame(8'h10, 32'h0000_0040, 32'h0000_BEEF, 1'b0, 0, 32'h0, 1);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 4) == 0) instr = 8'($urandom);
      else instr = {1'($urandom), 1'b0, 2'($urandom_range(0, 2)), 4'h0};
      addr = $urandom;
      if ($urandom_range(0, 3) == 0) addr[15:8] = 8'hA5;
      lat = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, TO));
      send_frame(instr, addr, $urandom, ($urandom_range(0, 9) == 0), lat, $urandom,
                 int'($urandom_range(0, 3)));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("rd_strobe_count", 32'(rd_strobes), 32'(exp_rd_strobes));
    chk("wr_q_drained", 32'(wr_q.size()), 32'h0);
    chk("rd_q_drained", 32'(rd_q.size()), 32'h0);
    chk("rsp_q_drained", 32'(rsp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
